// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder stage reused LSB-first over WIDTH clocks.
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// RUN    | one result bit per clock, busy=1
// DONE   | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry_ff;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             last;

    assign s    = sa[0] ^ sb[0] ^ carry_ff;
    assign co   = (sa[0] & sb[0]) | (sa[0] & carry_ff) | (sb[0] & carry_ff);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: the last RUN edge writes the completed word straight into sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                sa       <= a;
                sb       <= b;
                carry_ff <= cin;
                cnt      <= '0;
            end
        end else if (state == S_RUN) begin
            sa       <= sa >> 1;
            sb       <= sb >> 1;
            res      <= {s, res[WIDTH-1:1]};
            carry_ff <= co;
            cnt      <= cnt + CW'(1);
            if (last) begin
                sum  <= {s, res[WIDTH-1:1]};
                cout <= co;
                ovf  <= carry_ff ^ co;
            end
        end
    end

endmodule
